mant_prod_norm_round: RTL

- Pipelined stage directly downstream of the significand multiplier in the FP multiply datapath.
- Consumes the 2*SW-bit raw product of two SW-bit significands (hidden bit included).
- Produces the normalized, rounded SW-bit significand, an exponent-increment flag and status flags for the exponent/packing stage.
- Valid/ready handshake on both sides; 2-cycle latency.

---
 rtl/mant_prod_norm_round.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mant_prod_norm_round.sv
// ----------------------------------------------------------------------------
// mant_prod_norm_round
//
// Sits directly after the significand multiplier in the FP multiply datapath.
// It takes the 2*SW-bit raw product of two SW-bit significands (hidden bit
// included). It produces the normalized, rounded SW-bit significand, an
// exponent-increment flag and status flags for the exponent/packing stage.
// The stage is a two-deep pipeline with valid/ready on both sides, so the
// latency is 2 cycles and the throughput is one beat per cycle.
//
// Optional feature: define MNR_ROUND_MODE_EN to add selectable rounding
// (Round_mode_i, Sign_i). Without it the rounding is fixed round-to-nearest-even.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   Data_S_i      [2*SW-1:0] raw significand product
//   Valid_i       input beat valid
//   Ready_o       stage can accept a beat (combinational from stage state)
//   Data_M_o      [SW-1:0] normalized, rounded significand, hidden bit at MSB
//   Exp_inc_o     exponent must be incremented by 1
//   Inexact_o     guard or sticky bit was nonzero
//   Denorm_o      product top two bits were 00 (unnormalized operand)
//   Valid_o       output beat valid
//   Ready_i       downstream accepts beat
//   Round_mode_i  [1:0] 00 RNE, 01 RTZ, 10 +inf, 11 -inf (MNR_ROUND_MODE_EN)
//   Sign_i        result sign, used by directed rounding (MNR_ROUND_MODE_EN)
// ----------------------------------------------------------------------------
module mant_prod_norm_round #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*SW-1:0] Data_S_i,
    input  logic            Valid_i,
    output logic            Ready_o,
`ifdef MNR_ROUND_MODE_EN
    input  logic [1:0]      Round_mode_i,
    input  logic            Sign_i,
`endif
    output logic [SW-1:0]   Data_M_o,
    output logic            Exp_inc_o,
    output logic            Inexact_o,
    output logic            Denorm_o,
    output logic            Valid_o,
    input  logic            Ready_i
);

    localparam int PW = 2 * SW;

    // Decides whether to add one ulp.
    function automatic logic round_up(input logic       lsb,
                                      input logic       g,
                                      input logic       s,
                                      input logic [1:0] rm,
                                      input logic       sign);
        logic up;
        case (rm)
            2'b00:   up = g & (s | lsb);
            2'b01:   up = 1'b0;
            2'b10:   up = ~sign & (g | s);
            default: up = sign & (g | s);
        endcase
        return up;
    endfunction

    logic            vld_p1_q, vld_p1_d;
    logic [PW-1:0]   prod_p1_q;
    logic [1:0]      rm_p1;
    logic            sign_p1;

    logic            vld_p2_q, vld_p2_d;
    logic [SW-1:0]   mant_p2_q, mant_p2_d;
    logic            inc_p2_q, inc_p2_d;
    logic            inex_p2_q, inex_p2_d;
    logic            den_p2_q, den_p2_d;

    logic            s2_adv;
    logic            load_p1;
    logic            load_p2;

    logic            sh;
    logic [SW-1:0]   m;
    logic            g;
    logic            s;
    logic            up;
    logic [SW:0]     mr;
    logic            ovf;

    assign s2_adv  = ~vld_p2_q | Ready_i;
    assign Ready_o = ~vld_p1_q | s2_adv;
    assign load_p1 = Valid_i & Ready_o;
    assign load_p2 = vld_p1_q & s2_adv;

    // ---- stage 1: capture raw product ----
    always_comb begin
        vld_p1_d = vld_p1_q;
        if (Ready_o) begin
            vld_p1_d = Valid_i;
        end
    end

    // The product register carries data only, so reset leaves it alone.
    always_ff @(posedge clk) begin
        if (load_p1) begin
            prod_p1_q <= Data_S_i;
        end
    end

`ifdef MNR_ROUND_MODE_EN
    logic [1:0] rm_p1_q;
    logic       sign_p1_q;

    always_ff @(posedge clk) begin
        if (load_p1) begin
            rm_p1_q   <= Round_mode_i;
            sign_p1_q <= Sign_i;
        end
    end

    assign rm_p1   = rm_p1_q;
    assign sign_p1 = sign_p1_q;
`else
    assign rm_p1   = 2'b00;
    assign sign_p1 = 1'b0;
`endif

    // ---- stage 2: normalize, round, register results ----
    always_comb begin
        sh = prod_p1_q[PW-1];
        if (sh) begin
            m = prod_p1_q[PW-1:SW];
            g = prod_p1_q[SW-1];
            s = |prod_p1_q[SW-2:0];
        end else begin
            m = prod_p1_q[PW-2:SW-1];
            g = prod_p1_q[SW-2];
            s = |prod_p1_q[SW-3:0];
        end
        up  = round_up(m[0], g, s, rm_p1, sign_p1);
        mr  = {1'b0, m} + {{SW{1'b0}}, up};
        // A carry out can only happen when sh=0 and M is all ones. The result
        // is then exactly 2.0, which renormalizes to 1.0 with exponent + 1.
        ovf = mr[SW];
    end

    always_comb begin
        vld_p2_d  = vld_p2_q;
        mant_p2_d = mant_p2_q;
        inc_p2_d  = inc_p2_q;
        inex_p2_d = inex_p2_q;
        den_p2_d  = den_p2_q;
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
        end
        if (load_p2) begin
            mant_p2_d = ovf ? {1'b1, {(SW-1){1'b0}}} : mr[SW-1:0];
            inc_p2_d  = sh | ovf;
            inex_p2_d = g | s;
            // A zero product is not flagged as unnormalized.
            den_p2_d  = (prod_p1_q[PW-1:PW-2] == 2'b00) & (|prod_p1_q);
        end
    end

    // The output registers are reset as well, so Data_M_o and the flags
    // read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            mant_p2_q <= '0;
            inc_p2_q  <= 1'b0;
            inex_p2_q <= 1'b0;
            den_p2_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            mant_p2_q <= mant_p2_d;
            inc_p2_q  <= inc_p2_d;
            inex_p2_q <= inex_p2_d;
            den_p2_q  <= den_p2_d;
        end
    end

    assign Valid_o   = vld_p2_q;
    assign Data_M_o  = mant_p2_q;
    assign Exp_inc_o = inc_p2_q;
    assign Inexact_o = inex_p2_q;
    assign Denorm_o  = den_p2_q;

endmodule
